// File: rtl/coe_loader.sv
// Receives framed memory images over a UART byte stream and writes them into one of REGIONS memories.
// Define COE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after each frame.
module coe_loader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 14,
    parameter int REGIONS = 2,
    parameter int GAP_CYC = 1_000_000
) (
    input  logic               iFpgaClock,
    input  logic               iFpgaResetN,
    input  logic               iStartLoad,
    input  logic               iRxValid,
    input  logic [7:0]         iRxByte,
    output logic [REGIONS-1:0] oWriteEnable,
    output logic [ADDR_W-1:0]  oWriteAddress,
    output logic [DATA_W-1:0]  oWriteData,
    output logic               oCpuHold,
    output logic               oDone,
    output logic               oError
);

    // state      | meaning
    // IDLE       | after reset, CPU released, waiting for iStartLoad
    // HDR_REGION | waiting for region byte (0xFF ends the session)
    // HDR_CNT_HI | waiting for word count high byte
    // HDR_CNT_LO | waiting for word count low byte
    // DATA       | assembling words LSB first and writing them
    // CHECK      | waiting for the frame XOR checksum byte
    // DONE       | session finished cleanly, CPU released
    // ERROR      | session failed, CPU held until a new session succeeds
    typedef enum logic [2:0] {
        IDLE, HDR_REGION, HDR_CNT_HI, HDR_CNT_LO, DATA, CHECK, DONE, ERROR
    } state_t;

    localparam int BYTES = DATA_W / 8;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int REG_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [16:0]      MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYC - 1);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(BYTES - 1);
`ifdef COE_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHECK;
`else
    localparam state_t AFTER_DATA = HDR_REGION;
`endif

    state_t             state;
    logic [REG_W-1:0]   region;
    logic [7:0]         cntHi;
    logic [16:0]        wordsLeft;
    logic [ADDR_W-1:0]  wordAddr;
    logic [BI_W-1:0]    byteIdx;
    logic [DATA_W-1:0]  wordBuf;
    logic [GAP_W-1:0]   gapCnt;
`ifdef COE_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    logic [16:0]        frameCount;
    logic [DATA_W-1:0]  nextWord;

    assign frameCount = {1'b0, cntHi, iRxByte};

    always_comb begin
        nextWord = wordBuf;
        nextWord[{byteIdx, 3'b000} +: 8] = iRxByte;
    end

    always_ff @(posedge iFpgaClock or negedge iFpgaResetN) begin
        if (!iFpgaResetN) begin
            state         <= IDLE;
            region        <= '0;
            cntHi         <= '0;
            wordsLeft     <= '0;
            wordAddr      <= '0;
            byteIdx       <= '0;
            wordBuf       <= '0;
            gapCnt        <= '0;
`ifdef COE_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
            oWriteEnable  <= '0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
            oCpuHold      <= 1'b0;
            oDone         <= 1'b0;
            oError        <= 1'b0;
        end else begin
            oWriteEnable <= '0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (iStartLoad) begin
                        state    <= HDR_REGION;
                        oDone    <= 1'b0;
                        oError   <= 1'b0;
                        oCpuHold <= 1'b1;
                    end
                end
                HDR_REGION: begin
                    if (iRxValid) begin
                        gapCnt   <= GAP_LOAD;
                        wordAddr <= '0;
                        byteIdx  <= '0;
`ifdef COE_LOADER_CHECKSUM_EN
                        csum     <= iRxByte;
`endif
                        if (iRxByte == 8'hFF) begin
                            state    <= DONE;
                            oDone    <= 1'b1;
                            oCpuHold <= 1'b0;
                        end else if (iRxByte < 8'(REGIONS)) begin
                            region <= REG_W'(iRxByte);
                            state  <= HDR_CNT_HI;
                        end else begin
                            state  <= ERROR;
                            oError <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Mid-frame states: every byte reloads the gap timer.
                    if (iRxValid) begin
                        gapCnt <= GAP_LOAD;
`ifdef COE_LOADER_CHECKSUM_EN
                        csum   <= csum ^ iRxByte;
`endif
                        case (state)
                            HDR_CNT_HI: begin
                                cntHi <= iRxByte;
                                state <= HDR_CNT_LO;
                            end
                            HDR_CNT_LO: begin
                                if (frameCount > MAX_WORDS) begin
                                    state  <= ERROR;
                                    oError <= 1'b1;
                                end else if (frameCount == 17'd0) begin
                                    state <= AFTER_DATA;
                                end else begin
                                    wordsLeft <= frameCount;
                                    state     <= DATA;
                                end
                            end
                            DATA: begin
                                wordBuf <= nextWord;
                                if (byteIdx == LAST_BYTE) begin
                                    byteIdx       <= '0;
                                    oWriteEnable  <= REGIONS'(1) << region;
                                    oWriteAddress <= wordAddr;
                                    oWriteData    <= nextWord;
                                    wordAddr      <= wordAddr + 1'b1;
                                    wordsLeft     <= wordsLeft - 1'b1;
                                    if (wordsLeft == 17'd1) state <= AFTER_DATA;
                                end else begin
                                    byteIdx <= byteIdx + 1'b1;
                                end
                            end
                            CHECK: begin
`ifdef COE_LOADER_CHECKSUM_EN
                                if (iRxByte == csum) begin
                                    state <= HDR_REGION;
                                end else begin
                                    state  <= ERROR;
                                    oError <= 1'b1;
                                end
`else
                                state <= HDR_REGION;
`endif
                            end
                            default: ;
                        endcase
                    end else if (gapCnt == '0) begin
                        state  <= ERROR;
                        oError <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/coe_loader.md
COE_LOADER -- requirements
Module: coe_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width; multiple of 8, 8..64.
REQ-002 SHALL have parameter ADDR_W, default 14, word address width; 1..16.
REQ-003 SHALL have parameter REGIONS, default 2, number of target memories (0 = instruction, 1 = data); 1..8.
REQ-004 SHALL have parameter GAP_CYC, default 1_000_000, maximum idle clocks between bytes inside a frame.
REQ-005 SHALL have port iFpgaClock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port iFpgaResetN, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port iStartLoad, input, 1, one-cycle pulse that begins a load session.
REQ-008 SHALL have port iRxValid, input, 1, one-cycle strobe marking a received UART byte.
REQ-009 SHALL have port iRxByte, input, 8, received byte, valid with iRxValid.
REQ-010 SHALL have port oWriteEnable, output, REGIONS, one-hot memory write strobe.
REQ-011 SHALL have port oWriteAddress, output, ADDR_W, word address of the write.
REQ-012 SHALL have port oWriteData, output, DATA_W, word to write.
REQ-013 SHALL have port oCpuHold, output, 1, high while a session is active or failed; CPU held in reset.
REQ-014 SHALL have port oDone, output, 1, high after a successful session until the next iStartLoad.
REQ-015 SHALL have port oError, output, 1, high after a failed session until the next iStartLoad.

Function
REQ-016 SHALL implement states IDLE, HDR_REGION, HDR_CNT_HI, HDR_CNT_LO, DATA, CHECK, DONE, ERROR.
REQ-017 SHALL move IDLE/DONE/ERROR -> HDR_REGION on iStartLoad, clear oDone/oError, set oCpuHold; iStartLoad in other states is ignored.
REQ-018 SHALL frame each region: region byte, count high byte, count low byte, count words of DATA_W/8 bytes each, least-significant byte first.
REQ-019 SHALL treat region byte 0xFF in HDR_REGION as end of session -> DONE, with oCpuHold low and oDone high on the next cycle.
REQ-020 SHALL go to ERROR if region byte is neither 0xFF nor < REGIONS, or if count > 2**ADDR_W.
REQ-021 SHALL, when count = 0, skip DATA and go to CHECK (with macro) or HDR_REGION (without).
REQ-022 SHALL assert oWriteEnable[region] for exactly one cycle, the cycle after the last byte of a word is accepted, with oWriteAddress/oWriteData stable during that cycle.
REQ-023 SHALL restart the word address at 0 for each frame, increment it by 1 per word, and never wrap within a frame.
REQ-024 SHALL keep oWriteEnable all-zero outside the REQ-022 cycles, including in ERROR and DONE.
REQ-025 SHALL count idle clocks while in HDR_CNT_HI, HDR_CNT_LO, DATA or CHECK; on reaching GAP_CYC with no iRxValid, enter ERROR; any iRxValid clears the counter.
REQ-026 SHALL ignore iRxValid in IDLE, DONE and ERROR.
REQ-027 SHALL keep oCpuHold high in ERROR until the next iStartLoad succeeds.
REQ-028 SHALL give iStartLoad priority over a coincident iRxValid; that byte is discarded.

Reset
REQ-029 SHALL, while iFpgaResetN is low, force state IDLE, oWriteEnable 0, oWriteAddress 0, oWriteData 0, oCpuHold 0, oDone 0, oError 0, and clear the byte, word and gap counters.
REQ-030 SHALL abandon any frame in progress when reset asserts, with no partial word written.

Configuration
REQ-031 SHALL, with COE_LOADER_CHECKSUM_EN defined, expect after each frame's last word one byte equal to the XOR of all frame bytes (region, count, data); on mismatch go to ERROR, otherwise go to HDR_REGION.
REQ-032 SHALL, without COE_LOADER_CHECKSUM_EN, omit CHECK and go straight to HDR_REGION after the last word; words already written stay written in both builds.

Verification
REQ-033 SHALL cover: DATA_W=32, no macro, start, then 00 00 02 | 78 56 34 12 | EF BE AD DE | FF -> oWriteEnable=01 at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; oDone=1; oCpuHold=0.
REQ-034 SHALL cover: region byte 05 with REGIONS=2 -> oError=1, oCpuHold=1, no write; a new iStartLoad clears oError.
REQ-035 SHALL cover: GAP_CYC=16, stop after 2 data bytes -> ERROR 16 cycles after the last byte; no write.
REQ-036 SHALL cover: macro defined, frame 01 00 01 AA BB CC DD with checksum 0x01^0x00^0x01^0xAA^0xBB^0xCC^0xDD=0x00 -> write to region 1 at addr 0 with data 0xDDCCBBAA; wrong checksum 0x5A -> ERROR after the write.
REQ-037 SHALL cover: iFpgaResetN low mid-word -> all outputs 0 immediately; no write after release.
REQ-038 SHALL cover: count 0x0000 frame followed by FF -> no writes, oDone=1.
